// File: rtl/nanorv32_pmux_porta_pkg.sv
// Port A pin-mux shared definitions: pin count, register word indices and function-select encodings.
package nanorv32_pmux_porta_pkg;

    localparam int CHIP_PORT_A_WIDTH = 16;
    localparam int IRQ_STATUS_LSB    = 16;

    // Word index = reg_addr[4:2]; byte offset = index * 4
    typedef enum logic [2:0] {
        REG_GPIO_OUT = 3'd0,
        REG_GPIO_OE  = 3'd1,
        REG_GPIO_IN  = 3'd2,
        REG_FSEL_LO  = 3'd3,
        REG_FSEL_HI  = 3'd4,
        REG_PAD_IE   = 3'd5,
        REG_IRQ_RISE = 3'd6,
        REG_IRQ_FALL = 3'd7
    } reg_idx_e;

    typedef enum logic [1:0] {
        FSEL_GPIO = 2'd0,
        FSEL_AF1  = 2'd1,
        FSEL_AF2  = 2'd2,
        FSEL_AF3  = 2'd3
    } fsel_e;

endpackage

// File: rtl/nanorv32_pmux_porta_sync2.sv
// Two-flop synchronizer for a vector of asynchronous pad inputs.
module nanorv32_sync2 #(
    parameter int W = 16
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nanorv32_pmux_porta.sv
// Port A pin multiplexer / GPIO controller feeding the pad ring.
// Optional pin-change interrupt logic is built when NANORV32_PMUX_IRQ_EN is defined.
module nanorv32_pmux_porta
    import nanorv32_pmux_porta_pkg::*;
#(
    parameter int W = CHIP_PORT_A_WIDTH
) (
    input  logic           clk_in,
    input  logic           rst_n,
    input  logic           reg_sel,
    input  logic           reg_we,
    input  logic [4:0]     reg_addr,
    input  logic [31:0]    reg_wdata,
    output logic [31:0]    reg_rdata,
    output logic           reg_ready,
    input  logic [3*W-1:0] af_dout,
    input  logic [3*W-1:0] af_oe,
    output logic [W-1:0]   af_din,
    input  logic [W-1:0]   pad_pmux_din,
    output logic [W-1:0]   pmux_pad_dout,
    output logic [W-1:0]   pmux_pad_oe,
    output logic [W-1:0]   pmux_pad_ie,
    output logic           irq
);

    logic [W-1:0]      gpio_out;
    logic [W-1:0]      gpio_oe;
    logic [W-1:0]      pad_ie;
    logic [W-1:0][1:0] fsel;
    logic [W-1:0]      sync_in;
    logic [W-1:0]      gpio_in;
    logic [W-1:0]      dout_nxt;
    logic [W-1:0]      oe_nxt;
    logic [31:0]       rd_word;
    logic              rd_pend;
    logic              wr_en;
    logic              rd_en;
    reg_idx_e          idx;
    logic              unused_bits;

    assign idx         = reg_idx_e'(reg_addr[4:2]);
    assign wr_en       = reg_sel & reg_we;
    assign rd_en       = reg_sel & ~reg_we & ~rd_pend;
    // Write completes combinationally; held low while in reset so an aborted access never looks done
    assign reg_ready   = rst_n & (wr_en | rd_pend);
    assign unused_bits = ^{reg_addr[1:0], reg_wdata};

    nanorv32_sync2 #(.W(W)) u_sync2 (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .d      (pad_pmux_din),
        .q      (sync_in)
    );

    assign gpio_in = sync_in & pad_ie;
    assign af_din  = gpio_in;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            gpio_out <= '0;
            gpio_oe  <= '0;
            pad_ie   <= '1;
            fsel     <= '0;
        end else if (wr_en) begin
            case (idx)
                REG_GPIO_OUT: gpio_out <= reg_wdata[W-1:0];
                REG_GPIO_OE:  gpio_oe  <= reg_wdata[W-1:0];
                REG_PAD_IE:   pad_ie   <= reg_wdata[W-1:0];
                REG_FSEL_LO: begin
                    for (int i = 0; i < 8; i++)
                        if (i < W) fsel[i] <= reg_wdata[2*i +: 2];
                end
                REG_FSEL_HI: begin
                    for (int i = 0; i < 8; i++)
                        if (i + 8 < W) fsel[i+8] <= reg_wdata[2*i +: 2];
                end
                default: ;
            endcase
        end
    end

`ifdef NANORV32_PMUX_IRQ_EN
    logic [W-1:0] irq_rise;
    logic [W-1:0] irq_fall;
    logic [W-1:0] irq_status;
    logic [W-1:0] sync_prev;
    logic [W-1:0] irq_set;
    logic [W-1:0] irq_clr;

    assign irq_set = (sync_in & ~sync_prev & irq_rise) | (~sync_in & sync_prev & irq_fall);
    assign irq_clr = (wr_en && idx == REG_IRQ_RISE) ? reg_wdata[IRQ_STATUS_LSB +: W] : '0;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            irq_rise   <= '0;
            irq_fall   <= '0;
            irq_status <= '0;
            sync_prev  <= '0;
            irq         <= 1'b0;
        end else begin
            sync_prev  <= sync_in;
            // New edge beats a simultaneous write-1-to-clear so no event is lost
            irq_status <= (irq_status & ~irq_clr) | irq_set;
            irq        <= |irq_status;
            if (wr_en && idx == REG_IRQ_RISE) irq_rise <= reg_wdata[W-1:0];
            if (wr_en && idx == REG_IRQ_FALL) irq_fall <= reg_wdata[W-1:0];
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_word = '0;
        case (idx)
            REG_GPIO_OUT: rd_word[W-1:0] = gpio_out;
            REG_GPIO_OE:  rd_word[W-1:0] = gpio_oe;
            REG_GPIO_IN:  rd_word[W-1:0] = gpio_in;
            REG_PAD_IE:   rd_word[W-1:0] = pad_ie;
            REG_FSEL_LO: begin
                for (int i = 0; i < 8; i++)
                    if (i < W) rd_word[2*i +: 2] = fsel[i];
            end
            REG_FSEL_HI: begin
                for (int i = 0; i < 8; i++)
                    if (i + 8 < W) rd_word[2*i +: 2] = fsel[i+8];
            end
`ifdef NANORV32_PMUX_IRQ_EN
            REG_IRQ_RISE: begin
                rd_word[W-1:0]                = irq_rise;
                rd_word[IRQ_STATUS_LSB +: W]  = irq_status;
            end
            REG_IRQ_FALL: rd_word[W-1:0] = irq_fall;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            reg_rdata <= '0;
            rd_pend   <= 1'b0;
        end else begin
            rd_pend <= rd_en;
            if (rd_en) reg_rdata <= rd_word;
        end
    end

    // One mux level per pin, then a register: an FSEL change lands on a single edge
    always_comb begin
        dout_nxt = '0;
        oe_nxt   = '0;
        for (int i = 0; i < W; i++) begin
            case (fsel[i])
                FSEL_AF1: begin
                    dout_nxt[i] = af_dout[i];
                    oe_nxt[i]   = af_oe[i];
                end
                FSEL_AF2: begin
                    dout_nxt[i] = af_dout[W+i];
                    oe_nxt[i]   = af_oe[W+i];
                end
                FSEL_AF3: begin
                    dout_nxt[i] = af_dout[2*W+i];
                    oe_nxt[i]   = af_oe[2*W+i];
                end
                default: begin
                    dout_nxt[i] = gpio_out[i];
                    oe_nxt[i]   = gpio_oe[i];
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pmux_pad_dout <= '0;
            pmux_pad_oe   <= '0;
            pmux_pad_ie   <= '1;
        end else begin
            pmux_pad_dout <= dout_nxt;
            pmux_pad_oe   <= oe_nxt;
            pmux_pad_ie   <= pad_ie;
        end
    end

endmodule

// File: tb/tb_nanorv32_pmux_porta.sv
// Directed bench for nanorv32_pmux_porta; read expectations go through a scoreboard queue.
module tb_nanorv32_pmux_porta;

    localparam int W = 16;

    logic           clk_in = 1'b0;
    logic           rst_n  = 1'b0;
    logic           reg_sel = 1'b0;
    logic           reg_we  = 1'b0;
    logic [4:0]     reg_addr = '0;
    logic [31:0]    reg_wdata = '0;
    logic [31:0]    reg_rdata;
    logic           reg_ready;
    logic [3*W-1:0] af_dout = '0;
    logic [3*W-1:0] af_oe   = '0;
    logic [W-1:0]   af_din;
    logic [W-1:0]   pad_pmux_din = '0;
    logic [W-1:0]   pmux_pad_dout;
    logic [W-1:0]   pmux_pad_oe;
    logic [W-1:0]   pmux_pad_ie;
    logic           irq;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];

    nanorv32_pmux_porta #(.W(W)) dut (
        .clk_in        (clk_in),
        .rst_n         (rst_n),
        .reg_sel       (reg_sel),
        .reg_we        (reg_we),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_rdata     (reg_rdata),
        .reg_ready     (reg_ready),
        .af_dout       (af_dout),
        .af_oe         (af_oe),
        .af_din        (af_din),
        .pad_pmux_din  (pad_pmux_din),
        .pmux_pad_dout (pmux_pad_dout),
        .pmux_pad_oe   (pmux_pad_oe),
        .pmux_pad_ie   (pmux_pad_ie),
        .irq           (irq)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic bus_write(input logic [4:0] addr, input logic [31:0] data, input string tag);
        @(negedge clk_in);
        reg_sel   = 1'b1;
        reg_we    = 1'b1;
        reg_addr  = addr;
        reg_wdata = data;
        #1 check({tag, "_wr_ready"}, {31'd0, reg_ready}, 32'd1);
        @(posedge clk_in);
        #1;
        reg_sel = 1'b0;
        reg_we  = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] addr, input logic [31:0] exp, input string tag);
        int lat;
        bit got;
        exp_q.push_back(exp);
        @(negedge clk_in);
        reg_sel  = 1'b1;
        reg_we   = 1'b0;
        reg_addr = addr;
        got = 1'b0;
        lat = 0;
        for (int c = 0; c < 4 && !got; c++) begin
            @(negedge clk_in);
            lat = c + 1;
            if (reg_ready) got = 1'b1;
        end
        reg_sel = 1'b0;
        vectors++;
        assert (got) else begin
            miscompares++;
            $error("FAIL %s_timeout observed=no_ready expected=ready", tag);
        end
        if (got) begin
            check({tag, "_rd_lat"}, lat, 32'd1);
            check(tag, reg_rdata, exp_q.pop_front());
        end else begin
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        // 1: reset values
        tick(3);
        check("rst_ready", {31'd0, reg_ready}, 32'd0);
        check("rst_oe", {16'd0, pmux_pad_oe}, 32'h0);
        check("rst_ie", {16'd0, pmux_pad_ie}, 32'hFFFF);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        tick(1);
        check("rst_rdata", reg_rdata, 32'h0);
        check("rst_dout", {16'd0, pmux_pad_dout}, 32'h0);
        bus_read(5'h14, 32'h0000FFFF, "rd_pad_ie_rst");
        bus_read(5'h04, 32'h00000000, "rd_oe_rst");

        // 2: GPIO outputs, one-cycle pad latency
        bus_write(5'h04, 32'h000000FF, "gpio_oe");
        bus_write(5'h00, 32'h000000A5, "gpio_out");
        tick(1);
        check("dout_not_yet", {16'd0, pmux_pad_dout}, 32'h0);
        check("oe_after_wr", {16'd0, pmux_pad_oe}, 32'h00FF);
        tick(1);
        check("dout_after_wr", {16'd0, pmux_pad_dout}, 32'h00A5);
        bus_read(5'h00, 32'h000000A5, "rd_gpio_out");

        // 3: alternate functions
        af_dout[1] = 1'b1;
        af_oe[1]   = 1'b1;
        af_dout[2*W+9] = 1'b1;
        af_oe[2*W+9]   = 1'b1;
        bus_write(5'h0C, 32'h00000004, "fsel_lo");
        bus_write(5'h10, 32'h0000000C, "fsel_hi");
        tick(2);
        check("af_dout", {16'd0, pmux_pad_dout}, 32'h02A7);
        check("af_oe", {16'd0, pmux_pad_oe}, 32'h02FF);
        af_dout[1] = 1'b0;
        tick(1);
        check("af_change", {16'd0, pmux_pad_dout}, 32'h02A5);
        bus_read(5'h0C, 32'h00000004, "rd_fsel_lo");
        bus_read(5'h10, 32'h0000000C, "rd_fsel_hi");

        // 4: input path
        @(negedge clk_in);
        pad_pmux_din = 16'h8001;
        tick(1);
        check("din_lat1", {16'd0, af_din}, 32'h0);
        tick(1);
        check("din_lat2", {16'd0, af_din}, 32'h8001);
        bus_read(5'h08, 32'h00008001, "rd_gpio_in");
        bus_write(5'h14, 32'h00000001, "pad_ie");
        bus_read(5'h08, 32'h00000001, "rd_gpio_in_masked");
        check("af_din_masked", {16'd0, af_din}, 32'h0001);
        check("pad_ie_out", {16'd0, pmux_pad_ie}, 32'h0001);

        // 5: pin-change interrupt
`ifdef NANORV32_PMUX_IRQ_EN
        bus_write(5'h18, 32'h00000008, "irq_rise");
        @(negedge clk_in);
        pad_pmux_din = 16'h8009;
        tick(4);
        check("irq_set", {31'd0, irq}, 32'd1);
        bus_read(5'h18, 32'h00080008, "rd_status");
        bus_write(5'h18, 32'h00080008, "w1c");
        tick(2);
        check("irq_clr", {31'd0, irq}, 32'd0);
        bus_read(5'h18, 32'h00000008, "rd_status_clr");
        @(negedge clk_in);
        pad_pmux_din = 16'h8001;
        tick(4);
        bus_read(5'h18, 32'h00000008, "rd_no_fall");
        @(negedge clk_in);
        pad_pmux_din = 16'h8009;
        tick(1);
        bus_write(5'h18, 32'h00080008, "w1c_race");
        bus_read(5'h18, 32'h00080008, "rd_set_wins");
        check("irq_race", {31'd0, irq}, 32'd1);
        bus_write(5'h1C, 32'h00000008, "irq_fall");
        bus_write(5'h18, 32'h00080000, "w1c_all");
        bus_read(5'h1C, 32'h00000008, "rd_fall");
        @(negedge clk_in);
        pad_pmux_din = 16'h8001;
        tick(4);
        bus_read(5'h18, 32'h00080000, "rd_fall_status");
`else
        bus_write(5'h18, 32'h00000008, "irq_rise_off");
        bus_write(5'h1C, 32'h00000008, "irq_fall_off");
        @(negedge clk_in);
        pad_pmux_din = 16'h8009;
        tick(4);
        check("irq_off", {31'd0, irq}, 32'd0);
        bus_read(5'h18, 32'h00000000, "rd_rise_off");
        bus_read(5'h1C, 32'h00000000, "rd_fall_off");
`endif

        // 6: reset during a pending read, and during a write
        @(negedge clk_in);
        reg_sel  = 1'b1;
        reg_we   = 1'b0;
        reg_addr = 5'h14;
        @(posedge clk_in);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ready", {31'd0, reg_ready}, 32'd0);
        check("abort_rdata", reg_rdata, 32'h0);
        check("abort_dout", {16'd0, pmux_pad_dout}, 32'h0);
        check("abort_oe", {16'd0, pmux_pad_oe}, 32'h0);
        check("abort_ie", {16'd0, pmux_pad_ie}, 32'hFFFF);
        check("abort_irq", {31'd0, irq}, 32'd0);
        check("abort_din", {16'd0, af_din}, 32'h0);
        reg_we    = 1'b1;
        reg_addr  = 5'h04;
        reg_wdata = 32'h0000FFFF;
        tick(2);
        check("abort_wr_ready", {31'd0, reg_ready}, 32'd0);
        reg_sel = 1'b0;
        reg_we  = 1'b0;
        rst_n   = 1'b1;
        bus_read(5'h04, 32'h00000000, "rd_oe_after_abort");
        bus_read(5'h14, 32'h0000FFFF, "rd_ie_after_abort");

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
